// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock timekeeping block.
// Contents:
//   set_state_e     - set FSM encoding (RUN / SET_HOUR / SET_MIN, 11 illegal)
//   BCD_HOUR_MAX    - largest legal packed-BCD hour (23)
//   BCD_MINSEC_MAX  - largest legal packed-BCD minute/second (59)
//   bcd_inc()       - packed-BCD increment with wrap to 00 at a maximum
package clock_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_SET_HOUR = 2'b01,
    ST_SET_MIN  = 2'b10,
    ST_ILLEGAL  = 2'b11
  } set_state_e;

  localparam logic [7:0] BCD_HOUR_MAX   = 8'h23;
  localparam logic [7:0] BCD_MINSEC_MAX = 8'h59;

  // Packed-BCD values compare correctly as plain binary, so ">= max" both
  // detects the wrap point and forces any out-of-range value back to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] value,
                                         input logic [7:0] max);
    logic [7:0] result;
    if (value >= max) begin
      result = 8'h00;
    end else if (value[3:0] >= 4'd9) begin
      result = {value[7:4] + 4'd1, 4'h0};
    end else begin
      result = {value[7:4], value[3:0] + 4'd1};
    end
    return result;
  endfunction

endpackage

// File: rtl/clock_time_ctrl_if.sv
// Button/tick inputs and display-side outputs of clock_time_ctrl.
// Ports:
//   tick_1hz, btn_mode, btn_inc, btn_fmt  - one-cycle pulses into the block
//   hour_bcd, min_bcd, sec_bcd            - packed-BCD time (24-hour hour)
//   mode_12h                              - 12/24-hour display flag
//   set_state                             - set FSM state
//   blink_hour, blink_min                 - digit-visible flags while editing
// Modports: master drives the pulses, slave (the controller) drives the time.
interface clock_time_ctrl_if;
  import clock_pkg::*;

  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_inc;
  logic       btn_fmt;
  logic [7:0] hour_bcd;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       mode_12h;
  set_state_e set_state;
  logic       blink_hour;
  logic       blink_min;

  modport master (
    output tick_1hz, btn_mode, btn_inc, btn_fmt,
    input  hour_bcd, min_bcd, sec_bcd, mode_12h, set_state,
           blink_hour, blink_min
  );

  modport slave (
    input  tick_1hz, btn_mode, btn_inc, btn_fmt,
    output hour_bcd, min_bcd, sec_bcd, mode_12h, set_state,
           blink_hour, blink_min
  );

endinterface

// File: rtl/clock_time_ctrl_bcd_counter.sv
// bcd_counter: 8-bit packed-BCD counter wrapping from MAX to 00.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset (loads INIT)
//   inc        - advance by one this edge
//   clr        - force 00 this edge (wins over inc)
//   value      - registered count
//   carry      - high during the cycle whose edge wraps MAX -> 00; it is
//                combinational so the next counter can step on that same edge
module bcd_counter
  import clock_pkg::*;
#(
  parameter logic [7:0] MAX  = BCD_MINSEC_MAX,
  parameter logic [7:0] INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] value,
  output logic       carry
);

  logic [7:0] value_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= INIT;
    end else if (clr) begin
      value_q <= 8'h00;
    end else if (inc) begin
      value_q <= bcd_inc(value_q, MAX);
    end
  end

  assign value = value_q;
  assign carry = inc & ~clr & (value_q >= MAX);

endmodule

// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: running BCD time of day plus the hour/minute set FSM.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset; time returns to INIT_HOUR:INIT_MIN:00
//   bus    - clock_time_ctrl_if.slave: tick/button pulses in, time, 12/24-hour
//            flag, set state and blink flags out (all registered)
module clock_time_ctrl
  import clock_pkg::*;
#(
  parameter logic [7:0] INIT_HOUR = 8'h12,
  parameter logic [7:0] INIT_MIN  = 8'h00
) (
  input  logic               clk,
  input  logic               rst_n,
  clock_time_ctrl_if.slave   bus
);

  set_state_e state_q, state_d;
  logic       phase_q, phase_d;
  logic       mode_12h_q;
  logic       blink_hour_q, blink_min_q;

  logic       sec_inc, sec_clr, sec_carry;
  logic       min_inc, min_carry;
  logic       hour_inc, hour_carry_unused;
  logic [7:0] sec_val, min_val, hour_val;

  logic       in_run, in_set_hour, in_set_min;
  logic       next_is_set;

  assign in_run      = (state_q == ST_RUN);
  assign in_set_hour = (state_q == ST_SET_HOUR);
  assign in_set_min  = (state_q == ST_SET_MIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    next_is_set = 1'b0;
    sec_inc     = 1'b0;
    sec_clr     = 1'b0;
    min_inc     = 1'b0;
    hour_inc    = 1'b0;

    case (state_q)
      ST_RUN:      if (bus.btn_mode) state_d = ST_SET_HOUR;
      ST_SET_HOUR: if (bus.btn_mode) state_d = ST_SET_MIN;
      ST_SET_MIN:  if (bus.btn_mode) state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase

    next_is_set = (state_d == ST_SET_HOUR) || (state_d == ST_SET_MIN);

    // Entering an edit state restarts the blink with digits visible; after
    // that each tick flips it while an edit state is held.
    if (next_is_set && (state_d != state_q)) begin
      phase_d = 1'b1;
    end else if ((in_set_hour || in_set_min) && bus.tick_1hz) begin
      phase_d = ~phase_q;
    end

    // Ticks only advance the time in RUN, and the carries only ripple in
    // RUN, so a minute wrap while editing never bumps the hour.
    sec_inc  = in_run & bus.tick_1hz;
    sec_clr  = in_set_min & bus.btn_mode;
    min_inc  = (in_run & sec_carry) |
               (in_set_min & bus.btn_inc & ~bus.btn_mode);
    hour_inc = (in_run & min_carry) |
               (in_set_hour & bus.btn_inc & ~bus.btn_mode);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q      <= 1'b1;
      mode_12h_q   <= 1'b0;
      blink_hour_q <= 1'b0;
      blink_min_q  <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      mode_12h_q   <= mode_12h_q ^ bus.btn_fmt;
      blink_hour_q <= (state_d == ST_SET_HOUR) & phase_d;
      blink_min_q  <= (state_d == ST_SET_MIN) & phase_d;
    end
  end

  bcd_counter #(
    .MAX  (BCD_MINSEC_MAX),
    .INIT (8'h00)
  ) u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (sec_inc),
    .clr   (sec_clr),
    .value (sec_val),
    .carry (sec_carry)
  );

  bcd_counter #(
    .MAX  (BCD_MINSEC_MAX),
    .INIT (INIT_MIN)
  ) u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (min_inc),
    .clr   (1'b0),
    .value (min_val),
    .carry (min_carry)
  );

  // There is no day counter, so the hour wrap goes nowhere.
  bcd_counter #(
    .MAX  (BCD_HOUR_MAX),
    .INIT (INIT_HOUR)
  ) u_hour (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hour_inc),
    .clr   (1'b0),
    .value (hour_val),
    .carry (hour_carry_unused)
  );

  assign bus.hour_bcd   = hour_val;
  assign bus.min_bcd    = min_val;
  assign bus.sec_bcd    = sec_val;
  assign bus.mode_12h   = mode_12h_q;
  assign bus.set_state  = state_q;
  assign bus.blink_hour = blink_hour_q;
  assign bus.blink_min  = blink_min_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed bench for clock_time_ctrl: reset values, RUN rollover, hour and
// minute editing with wrap, blink phase, simultaneous-input priority,
// 12/24-hour toggle and asynchronous reset in the middle of an edit.
module tb_clock_time_ctrl;
  import clock_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  clock_time_ctrl_if bus();

  clock_time_ctrl #(
    .INIT_HOUR (8'h12),
    .INIT_MIN  (8'h00)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_time(input string tag, input logic [7:0] h,
                          input logic [7:0] m, input logic [7:0] s);
    chk({tag, ".hour"}, 32'(bus.hour_bcd), 32'(h));
    chk({tag, ".min"},  32'(bus.min_bcd),  32'(m));
    chk({tag, ".sec"},  32'(bus.sec_bcd),  32'(s));
  endtask

  task automatic chk_ctl(input string tag, input logic [1:0] st,
                         input logic bh, input logic bm, input logic m12);
    chk({tag, ".state"},      32'(bus.set_state),  32'(st));
    chk({tag, ".blink_hour"}, 32'(bus.blink_hour), 32'(bh));
    chk({tag, ".blink_min"},  32'(bus.blink_min),  32'(bm));
    chk({tag, ".mode_12h"},   32'(bus.mode_12h),   32'(m12));
  endtask

  // Drive one cycle of inputs; returns 1 ns after the edge that samples them.
  task automatic step(input logic t, input logic m, input logic i,
                      input logic f);
    @(negedge clk);
    bus.tick_1hz = t;
    bus.btn_mode = m;
    bus.btn_inc  = i;
    bus.btn_fmt  = f;
    @(posedge clk);
    #1;
    bus.tick_1hz = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    bus.btn_fmt  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    rst_n        = 1'b0;
    bus.tick_1hz = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    bus.btn_fmt  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_time("reset", 8'h12, 8'h00, 8'h00);
    chk_ctl("reset", 2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // btn_inc does nothing in RUN
    step(0, 0, 1, 0);
    chk_time("run_inc", 8'h12, 8'h00, 8'h00);

    // Set 23:59 through the FSM
    step(0, 1, 0, 0);
    chk_ctl("enter_sh", 2'b01, 1'b1, 1'b0, 1'b0);
    repeat (11) step(0, 0, 1, 0);
    chk_time("hour_23", 8'h23, 8'h00, 8'h00);
    step(0, 1, 0, 0);
    chk_ctl("enter_sm", 2'b10, 1'b0, 1'b1, 1'b0);
    repeat (59) step(0, 0, 1, 0);
    chk_time("min_59", 8'h23, 8'h59, 8'h00);
    step(0, 1, 0, 0);
    chk_ctl("back_run", 2'b00, 1'b0, 1'b0, 1'b0);

    // Midnight rollover
    repeat (58) step(1, 0, 0, 0);
    chk_time("t_58", 8'h23, 8'h59, 8'h58);
    step(1, 0, 0, 0);
    chk_time("t_59", 8'h23, 8'h59, 8'h59);
    step(1, 0, 0, 0);
    chk_time("rollover", 8'h00, 8'h00, 8'h00);
    repeat (5) step(1, 0, 0, 0);
    chk_time("t_05", 8'h00, 8'h00, 8'h05);

    // SET_HOUR: wrap 23 -> 00, frozen clock, blink 1,0,1,0
    step(0, 1, 0, 0);
    chk_ctl("sh_entry", 2'b01, 1'b1, 1'b0, 1'b0);
    repeat (23) step(0, 0, 1, 0);
    chk_time("sh_23", 8'h23, 8'h00, 8'h05);
    step(0, 0, 1, 0);
    chk_time("sh_wrap", 8'h00, 8'h00, 8'h05);
    chk("sh_blink0", 32'(bus.blink_hour), 32'd1);
    step(1, 0, 0, 0);
    chk("sh_blink1", 32'(bus.blink_hour), 32'd0);
    chk_time("sh_frozen", 8'h00, 8'h00, 8'h05);
    step(1, 0, 0, 0);
    chk("sh_blink2", 32'(bus.blink_hour), 32'd1);
    step(1, 0, 0, 0);
    chk("sh_blink3", 32'(bus.blink_hour), 32'd0);

    // mode with inc: step wins, hour untouched
    step(0, 1, 1, 0);
    chk_ctl("mode_inc", 2'b10, 1'b0, 1'b1, 1'b0);
    chk_time("mode_inc", 8'h00, 8'h00, 8'h05);

    // SET_MIN: 09 -> 10, 59 -> 00 with no hour carry
    repeat (9) step(0, 0, 1, 0);
    chk("sm_09", 32'(bus.min_bcd), 32'h09);
    step(0, 0, 1, 0);
    chk("sm_10", 32'(bus.min_bcd), 32'h10);
    repeat (49) step(0, 0, 1, 0);
    chk("sm_59", 32'(bus.min_bcd), 32'h59);
    step(0, 0, 1, 0);
    chk_time("sm_wrap", 8'h00, 8'h00, 8'h05);
    step(1, 0, 0, 0);
    chk("sm_blink", 32'(bus.blink_min), 32'd0);
    chk_time("sm_frozen", 8'h00, 8'h00, 8'h05);

    // Leave SET_MIN on a tick: clear beats the tick
    step(1, 1, 0, 0);
    chk_ctl("exit_sm", 2'b00, 1'b0, 1'b0, 1'b0);
    chk_time("exit_sm", 8'h00, 8'h00, 8'h00);
    step(1, 0, 0, 0);
    chk_time("run_again", 8'h00, 8'h00, 8'h01);

    // 12/24-hour flag toggles, alongside a tick and alone
    step(1, 0, 0, 1);
    chk("fmt_on", 32'(bus.mode_12h), 32'd1);
    chk_time("fmt_on", 8'h00, 8'h00, 8'h02);
    step(0, 0, 0, 1);
    chk("fmt_off", 32'(bus.mode_12h), 32'd0);
    chk_time("fmt_off", 8'h00, 8'h00, 8'h02);

    // Asynchronous reset in the middle of a minute edit
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    repeat (3) step(0, 0, 1, 0);
    chk_ctl("pre_rst", 2'b10, 1'b0, 1'b1, 1'b1);
    chk("pre_rst.min", 32'(bus.min_bcd), 32'h03);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_time("async_rst", 8'h12, 8'h00, 8'h00);
    chk_ctl("async_rst", 2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 0);
    chk_time("post_rst", 8'h12, 8'h00, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_time_ctrl.md
# clock_time_ctrl

Timekeeping and time-set controller for the digital clock. Holds the running time as packed BCD hours, minutes and seconds, and advances it on a 1 Hz tick. A three-state set FSM, driven by debounced button pulses, lets the user edit hours and minutes. Also owns the 12/24-hour display-format flag, which goes to the downstream hour-format converter alongside the 24-hour BCD hour.

## Interface
- INIT_HOUR, 8'h12: BCD hour loaded at reset (00–23).
- INIT_MIN, 8'h00: BCD minute loaded at reset (00–59).
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- tick_1hz  in  1  one-cycle pulse, once per second
- btn_mode  in  1  one-cycle pulse (already debounced); steps the set FSM
- btn_inc  in  1  one-cycle pulse; increments the field being edited
- btn_fmt  in  1  one-cycle pulse; toggles mode_12h
- hour_bcd  out  8  current hour, packed BCD, always 24-hour, 00–23
- min_bcd  out  8  current minute, packed BCD, 00–59
- sec_bcd  out  8  current second, packed BCD, 00–59
- mode_12h  out  1  1 = 12-hour display, 0 = 24-hour display
- set_state  out  2  00 RUN, 01 SET_HOUR, 10 SET_MIN
- blink_hour  out  1  1 = hour digits visible, during SET_HOUR only
- blink_min  out  1  1 = minute digits visible, during SET_MIN only

## Operation
- All outputs are registered.
- Reset values:
  - hour_bcd = INIT_HOUR, min_bcd = INIT_MIN, sec_bcd = 8'h00
  - mode_12h = 0, set_state = RUN
  - blink phase = 1; blink_hour = blink_min = 0
- FSM on btn_mode: RUN → SET_HOUR → SET_MIN → RUN. Encoding 11 is unreachable and recovers to RUN.
- RUN, on each tick_1hz:
  - sec +1; 59 → 00 carries into min.
  - min 59 → 00 carries into hour.
  - hour 23 → 00; no day carry.
  - btn_inc is ignored.
- SET_HOUR:
  - Clock is frozen; tick_1hz drives only the blink phase.
  - btn_inc: hour +1, wrapping 23 → 00. min and sec are unchanged.
- SET_MIN:
  - Clock is frozen.
  - btn_inc: min +1, wrapping 59 → 00. No carry into hour.
- On the SET_MIN → RUN transition, sec is cleared to 00.
- BCD increment rules:
  - A units digit of 9 goes to 0 and increments tens.
  - Only valid BCD is ever produced: no nibble exceeds 9 and no value exceeds its maximum.
- Blink:
  - The phase is set to 1 on entry to SET_HOUR or SET_MIN.
  - The phase toggles on each tick_1hz while in a set state.
  - blink_hour = (state==SET_HOUR) & phase; blink_min = (state==SET_MIN) & phase.
- btn_fmt toggles mode_12h in any state and has no effect on the time registers.

## Timing
- Each input pulse is sampled on a rising clk edge; the result appears on the outputs at that same edge, so they are valid in the following cycle. Latency is 1 cycle.
- Carry ripple (sec → min → hour) completes within the same single edge; there are no intermediate values such as 00:59:60.
- Simultaneous events:
  - btn_mode with btn_inc: the mode step wins and the inc is dropped.
  - tick_1hz with btn_mode in RUN: the tick is applied and the state moves to SET_HOUR on the same edge.
  - tick_1hz with btn_mode in SET_MIN: sec is cleared (the clear wins over the tick), then the clock runs from the next tick.
  - btn_fmt is independent and is honoured alongside any other input.
- If rst_n is asserted mid-edit, the FSM returns to RUN and the time returns to INIT values immediately (asynchronously). Edits already made are lost.
- Inputs held high for several cycles count once per cycle. Pulse shaping is upstream.

## Structure
- Shared package clock_pkg:
  - state encoding constants ST_RUN, ST_SET_HOUR, ST_SET_MIN
  - BCD limit constants BCD_HOUR_MAX = 8'h23, BCD_MINSEC_MAX = 8'h59
- Sub-module bcd_counter, parameter MAX:
  - inputs inc and clr; outputs an 8-bit value and a one-cycle carry on wrap
  - instantiated three times, with the FSM gating inc/clr per state
- The FSM and blink logic sit at top level.

## Test plan
- Reset, then check outputs: hour 8'h12, min 8'h00, sec 8'h00, mode_12h 0, set_state 00, blinks 0.
- RUN at 23:59:58, apply 2 ticks: expect 23:59:59, then 00:00:00 after the second tick, with no intermediate invalid value.
- btn_mode to SET_HOUR at hour 8'h23, pulse btn_inc, apply 3 ticks: expect hour 8'h00, sec unchanged, blink_hour sequence 1,0,1,0.
- In SET_MIN at min 8'h09, pulse btn_inc: expect 8'h10. At min 8'h59, pulse btn_inc: expect 8'h00 with hour unchanged. Then btn_mode: expect RUN with sec 8'h00.
- btn_mode and btn_inc in the same cycle in SET_HOUR: expect SET_MIN with hour unchanged. btn_fmt twice: mode_12h goes 1, then 0, with time untouched.
- Assert rst_n mid-SET_MIN after edits: expect immediate return to RUN, INIT time and blinks 0.
